// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the WISC 5-stage pipeline: load-use, branch redirect, HLT drain, I/D-cache miss FSM.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
   parameter int NREG_W    = 4,
   parameter int DRAIN_CYC = 3
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W     = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREG_W-1:0] id_rs1,
   input  logic [NREG_W-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [NREG_W-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_reg_write,
   input  logic              id_branch_taken,
   input  logic              id_halt,
   input  logic              imem_miss,
   input  logic              imem_ready,
   input  logic              dmem_miss,
   input  logic              dmem_ready,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              ex_mem_en,
   output logic              mem_wb_en,
   output logic              halted
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  lu_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      RUN,
      IMISS,
      DMISS,
      HALT_DRAIN,
      HALTED
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               imiss_pend;
   logic               imiss_pend_next;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [DRAIN_W-1:0] drain_cnt_next;
   logic               drain_wait;
   logic               drain_wait_next;
   logic               lu;

   // R0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign lu = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         imiss_pend <= 1'b0;
         drain_cnt  <= '0;
         drain_wait <= 1'b0;
      end else begin
         state      <= state_next;
         imiss_pend <= imiss_pend_next;
         drain_cnt  <= drain_cnt_next;
         drain_wait <= drain_wait_next;
      end
   end

   always_comb begin
      state_next      = state;
      imiss_pend_next = imiss_pend;
      drain_cnt_next  = drain_cnt;
      drain_wait_next = drain_wait;
      pc_en           = 1'b1;
      if_id_en        = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_en       = 1'b1;
      mem_wb_en       = 1'b1;
      halted          = 1'b0;

      case (state)
         RUN: begin
            if (dmem_miss) begin
               pc_en           = 1'b0;
               if_id_en        = 1'b0;
               ex_mem_en       = 1'b0;
               mem_wb_en       = 1'b0;
               state_next      = DMISS;
               imiss_pend_next = imem_miss;
            end else if (lu) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end else if (id_halt) begin
               pc_en           = 1'b0;
               if_id_flush     = 1'b1;
               state_next      = HALT_DRAIN;
               drain_cnt_next  = '0;
               drain_wait_next = 1'b0;
            end else if (id_branch_taken) begin
               // The redirect cancels any fetch that is currently missing.
               if_id_flush = 1'b1;
            end else if (imem_miss) begin
               pc_en       = 1'b0;
               if_id_flush = 1'b1;
               state_next  = IMISS;
            end
         end

         IMISS: begin
            if (dmem_miss) begin
               pc_en           = 1'b0;
               if_id_en        = 1'b0;
               ex_mem_en       = 1'b0;
               mem_wb_en       = 1'b0;
               state_next      = DMISS;
               imiss_pend_next = 1'b1;
            end else begin
               if (lu) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end else begin
                  pc_en       = imem_ready;
                  if_id_flush = 1'b1;
               end
               if (imem_ready) begin
                  state_next = RUN;
               end
            end
         end

         DMISS: begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            if (dmem_ready) begin
               state_next      = imiss_pend ? IMISS : RUN;
               imiss_pend_next = 1'b0;
            end
         end

         HALT_DRAIN: begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            // A data miss freezes the drain until its fill returns, including the fill cycle.
            if (dmem_miss || drain_wait) begin
               ex_mem_en       = 1'b0;
               mem_wb_en       = 1'b0;
               drain_wait_next = !dmem_ready;
            end else if (drain_cnt == DRAIN_LAST) begin
               state_next = HALTED;
            end else begin
               drain_cnt_next = drain_cnt + DRAIN_W'(1);
            end
         end

         HALTED: begin
            halted      = 1'b1;
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end

         default: begin
            state_next = RUN;
         end
      endcase

      if (!rst_n) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         ex_mem_en   = 1'b0;
         mem_wb_en   = 1'b0;
         halted      = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic stall_event;
   logic lu_event;
   logic br_event;

   assign stall_event = rst_n && !pc_en && (state != HALTED);
   assign lu_event    = rst_n && lu && !dmem_miss && ((state == RUN) || (state == IMISS));
   assign br_event    = rst_n && (state == RUN) && !dmem_miss && !lu && !id_halt && id_branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         lu_cnt    <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_event && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (lu_event && (lu_cnt != {CNT_W{1'b1}})) begin
            lu_cnt <= lu_cnt + CNT_W'(1);
         end
         if (br_event && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model built from pending-miss flags and a drain countdown.
module tb_pipeline_hazard_ctrl;
   localparam int NREG_W    = 4;
   localparam int DRAIN_CYC = 3;

   // Stimulus word bits: {imem_miss, imem_ready, dmem_miss, dmem_ready, branch, halt, load_use}
   localparam logic [6:0] S_IM = 7'b1000000;
   localparam logic [6:0] S_IR = 7'b0100000;
   localparam logic [6:0] S_DM = 7'b0010000;
   localparam logic [6:0] S_DR = 7'b0001000;
   localparam logic [6:0] S_BR = 7'b0000100;
   localparam logic [6:0] S_HT = 7'b0000010;
   localparam logic [6:0] S_LU = 7'b0000001;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREG_W-1:0] id_rs1, id_rs2, ex_rd;
   logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write;
   logic              id_branch_taken, id_halt, imem_miss, imem_ready, dmem_miss, dmem_ready;
   logic              pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, halted;

   int n_vec = 0;
   int n_bad = 0;

   // Model state: outstanding fetch/data misses, remaining drain cycles, drain paused, halted.
   bit m_fetch_wait, m_data_wait, m_drain_paused, m_halted;
   int m_drain_left;

   logic [6:0] exp_v, care_v;
   wire  [6:0] act_v = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, halted};

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.NREG_W(NREG_W), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .id_branch_taken(id_branch_taken), .id_halt(id_halt),
      .imem_miss(imem_miss), .imem_ready(imem_ready), .dmem_miss(dmem_miss), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .halted(halted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [6:0] s);
      imem_miss       = s[6];
      imem_ready      = s[5];
      dmem_miss       = s[4];
      dmem_ready      = s[3];
      id_branch_taken = s[2];
      id_halt         = s[1];
      ex_mem_read     = s[0];
      ex_reg_write    = 1'b1;
      ex_rd           = 4'd5;
      id_rs1          = 4'd5;
      id_use_rs1      = 1'b1;
      id_rs2          = 4'd2;
      id_use_rs2      = 1'b1;
   endtask

   // Expected outputs for the current cycle, then advance the model across the coming edge.
   task automatic model_step();
      bit hz;
      bit e_pc, e_ien, e_ifl, e_efl, e_xm, e_mw, e_h;
      hz = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      {e_pc, e_ien, e_ifl, e_efl, e_xm, e_mw, e_h} = 7'b1100110;
      care_v = 7'h7f;
      if (!rst_n) begin
         {e_pc, e_ien, e_ifl, e_efl, e_xm, e_mw, e_h} = 7'b0011000;
         m_fetch_wait = 0; m_data_wait = 0; m_drain_paused = 0; m_halted = 0; m_drain_left = 0;
      end else if (m_halted) begin
         e_h = 1; e_pc = 0; e_ien = 0;
         care_v = 7'b1100001;
      end else if (m_data_wait) begin
         e_pc = 0; e_ien = 0; e_xm = 0; e_mw = 0;
         if (dmem_ready) m_data_wait = 0;
      end else if (m_drain_left > 0) begin
         e_pc = 0; e_ifl = 1;
         care_v = 7'b1010111;
         if (dmem_miss || m_drain_paused) begin
            e_xm = 0; e_mw = 0;
            m_drain_paused = !dmem_ready;
         end else begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
         end
      end else if (m_fetch_wait) begin
         if (dmem_miss) begin
            e_pc = 0; e_ien = 0; e_xm = 0; e_mw = 0;
            m_data_wait = 1;
         end else begin
            if (hz) begin
               e_pc = 0; e_ien = 0; e_efl = 1;
            end else begin
               e_pc = imem_ready; e_ifl = 1;
            end
            if (imem_ready) m_fetch_wait = 0;
         end
      end else begin
         if (dmem_miss) begin
            e_pc = 0; e_ien = 0; e_xm = 0; e_mw = 0;
            m_data_wait = 1; m_fetch_wait = imem_miss;
         end else if (hz) begin
            e_pc = 0; e_ien = 0; e_efl = 1;
         end else if (id_halt) begin
            e_pc = 0; e_ifl = 1;
            care_v = 7'b1010001;
            m_drain_left = DRAIN_CYC; m_drain_paused = 0;
         end else if (id_branch_taken) begin
            e_ifl = 1;
         end else if (imem_miss) begin
            e_pc = 0; e_ifl = 1;
            m_fetch_wait = 1;
         end
      end
      exp_v = {e_pc, e_ien, e_ifl, e_efl, e_xm, e_mw, e_h};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      apply('0);
      #3;
      model_step();
      n_vec++;
      if ((act_v & care_v) !== (exp_v & care_v)) begin
         n_bad++;
         $display("[TB] FAIL reset_hold: dut=%b model=%b", act_v, exp_v);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         apply('0);
         #3;
         model_step();
         n_vec++;
         if ((act_v & care_v) !== (exp_v & care_v)) begin
            n_bad++;
            $display("[TB] FAIL reset_release[%0d]: dut=%b model=%b", i, act_v, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      int stalls = 0;
      for (int i = 0; i < 3; i++) begin
         apply((i == 0) ? S_LU : 7'b0);
         #3;
         model_step();
         n_vec++;
         if ((act_v & care_v) !== (exp_v & care_v)) begin
            n_bad++;
            $display("[TB] FAIL load_use[%0d]: dut=%b model=%b", i, act_v, exp_v);
         end
         if (!pc_en && !if_id_en && id_ex_flush) stalls++;
         tick();
      end
      n_vec++;
      if (stalls !== 1) begin
         n_bad++;
         $display("[TB] FAIL load_use_len: stall cycles=%0d want 1", stalls);
      end
      apply('0);
      ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs1 = 4'd0; id_rs2 = 4'd0;
      #3;
      model_step();
      n_vec++;
      if ((act_v & care_v) !== (exp_v & care_v) || pc_en !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL load_use_r0: dut=%b model=%b", act_v, exp_v);
      end
      tick();
      apply('0);
      ex_mem_read = 1'b1; ex_rd = 4'd9; id_rs2 = 4'd9; id_use_rs1 = 1'b0;
      #3;
      model_step();
      n_vec++;
      if ((act_v & care_v) !== (exp_v & care_v) || if_id_en !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL load_use_rs2: dut=%b model=%b", act_v, exp_v);
      end
      tick();
   endtask

   task automatic test_branch();
      for (int i = 0; i < 3; i++) begin
         apply((i == 0) ? (S_BR | S_IM) : 7'b0);
         #3;
         model_step();
         n_vec++;
         if ((act_v & care_v) !== (exp_v & care_v) || pc_en !== 1'b1 || if_id_flush !== (i == 0)) begin
            n_bad++;
            $display("[TB] FAIL branch[%0d]: dut=%b model=%b", i, act_v, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_dmiss();
      logic [6:0] seq [6] = '{S_DM, S_DM, S_DM, S_DM | S_DR, 7'b0, 7'b0};
      int frozen = 0;
      for (int i = 0; i < 6; i++) begin
         apply(seq[i]);
         #3;
         model_step();
         n_vec++;
         if ((act_v & care_v) !== (exp_v & care_v)) begin
            n_bad++;
            $display("[TB] FAIL dmiss[%0d]: dut=%b model=%b", i, act_v, exp_v);
         end
         if ({pc_en, if_id_en, ex_mem_en, mem_wb_en} === 4'b0000) frozen++;
         tick();
      end
      n_vec++;
      if (frozen !== 4) begin
         n_bad++;
         $display("[TB] FAIL dmiss_len: frozen cycles=%0d want 4", frozen);
      end
   endtask

   task automatic test_nested_miss();
      logic [6:0] seq [8] = '{S_IM, S_IM, S_IM | S_DM, S_DM | S_DR, S_IM, S_IM, S_IM | S_IR, 7'b0};
      logic       want_pc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         apply(seq[i]);
         #3;
         model_step();
         n_vec++;
         if ((act_v & care_v) !== (exp_v & care_v) || pc_en !== want_pc[i]) begin
            n_bad++;
            $display("[TB] FAIL nested[%0d]: dut=%b model=%b", i, act_v, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_halt(input int pause);
      int waited = -1;
      logic [6:0] s;
      for (int i = 0; i < 20; i++) begin
         s = (i == 0) ? S_HT : 7'b0;
         if (pause != 0 && i == 2) s = S_DM;
         if (pause != 0 && i == 3) s = S_DM | S_DR;
         apply(s);
         #3;
         model_step();
         n_vec++;
         if ((act_v & care_v) !== (exp_v & care_v)) begin
            n_bad++;
            $display("[TB] FAIL halt_p%0d[%0d]: dut=%b model=%b", pause, i, act_v, exp_v);
         end
         if (halted === 1'b1 && waited < 0) waited = i - 1;
         tick();
         if (waited >= 0 && i > waited + 3) break;
      end
      n_vec++;
      if (waited !== DRAIN_CYC + pause) begin
         n_bad++;
         $display("[TB] FAIL halt_latency_p%0d: drain=%0d want %0d", pause, waited, DRAIN_CYC + pause);
      end
      rst_n = 1'b0;
      apply('0);
      #3;
      model_step();
      n_vec++;
      if ((act_v & care_v) !== (exp_v & care_v) || halted !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL halt_reset: dut=%b model=%b", act_v, exp_v);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_dmiss();
      for (int i = 0; i < 2; i++) begin
         apply(S_DM);
         #3;
         model_step();
         n_vec++;
         if ((act_v & care_v) !== (exp_v & care_v)) begin
            n_bad++;
            $display("[TB] FAIL rst_dmiss[%0d]: dut=%b model=%b", i, act_v, exp_v);
         end
         if (i == 0) tick();
      end
      #1;
      rst_n = 1'b0;
      #1;
      model_step();
      n_vec++;
      if (act_v !== 7'b0011000 || (act_v & care_v) !== (exp_v & care_v)) begin
         n_bad++;
         $display("[TB] FAIL rst_dmiss_force: dut=%b want 0011000", act_v);
      end
      tick();
      rst_n = 1'b1;
      apply('0);
      #3;
      model_step();
      n_vec++;
      if ((act_v & care_v) !== (exp_v & care_v) || pc_en !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL rst_dmiss_release: dut=%b model=%b", act_v, exp_v);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         rst_n           = ($urandom_range(0, 33) != 0);
         imem_miss       = ($urandom_range(0, 3) == 0);
         imem_ready      = ($urandom_range(0, 4) == 0);
         dmem_miss       = ($urandom_range(0, 7) == 0);
         dmem_ready      = ($urandom_range(0, 3) == 0);
         id_branch_taken = ($urandom_range(0, 5) == 0);
         id_halt         = ($urandom_range(0, 39) == 0);
         ex_mem_read     = $urandom_range(0, 1) == 1;
         ex_reg_write    = $urandom_range(0, 3) != 0;
         ex_rd           = NREG_W'($urandom_range(0, 3));
         id_rs1          = NREG_W'($urandom_range(0, 3));
         id_rs2          = NREG_W'($urandom_range(0, 3));
         id_use_rs1      = $urandom_range(0, 1) == 1;
         id_use_rs2      = $urandom_range(0, 1) == 1;
         #3;
         model_step();
         n_vec++;
         if ((act_v & care_v) !== (exp_v & care_v)) begin
            n_bad++;
            $display("[TB] FAIL random[%0d]: dut=%b model=%b care=%b", i, act_v, exp_v, care_v);
         end
         tick();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_dmiss();
      test_nested_miss();
      test_halt(0);
      test_halt(2);
      test_reset_mid_dmiss();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage IF/ID/EX/MEM/WB pipeline of the WISC CPU.
- Detects load-use hazards, taken-branch redirects (branches resolve in ID) and HLT drain.
- Sequences multi-cycle instruction-cache and data-cache miss stalls through a small FSM.
- Drives per-stage register enables and bubble/flush controls consumed by the pipeline registers and the hazard-tracking testbench.

Parameters:
- NREG_W, 4, register-index width (16 architectural registers, R0 hard-wired zero)
- DRAIN_CYC, 3, cycles after HLT leaves ID before halted asserts (EX, MEM, WB drain)
- CNT_W, 32, width of performance counters (optional feature)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  NREG_W  source reg 1 of instruction in ID
- id_rs2  in  NREG_W  source reg 2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  NREG_W  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_reg_write  in  1  EX instruction writes rd
- id_branch_taken  in  1  branch in ID resolved taken
- id_halt  in  1  HLT decoded in ID
- imem_miss  in  1  I-cache miss (level, current fetch)
- imem_ready  in  1  I-cache fill done (1-cycle pulse)
- dmem_miss  in  1  D-cache miss (level, current MEM access)
- dmem_ready  in  1  D-cache fill done (1-cycle pulse)
- pc_en  out  1  PC register update enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP into ID/EX
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- halted  out  1  CPU fully drained after HLT

Behaviour:
- FSM states: RUN, IMISS, DMISS, HALT_DRAIN, HALTED. Reset state RUN; imiss_pend=0; drain counter=0.
- Outputs are combinational from state and inputs.
- While rst_n=0, outputs are forced to: all enables 0, if_id_flush=1, id_ex_flush=1, halted=0.
- Load-use hazard (lu) = ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN outputs, applied in priority order:
  - dmem_miss: all enables 0, no flushes. Next state DMISS; imiss_pend<=imem_miss.
  - lu: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. id_branch_taken and id_halt are ignored this cycle. Single cycle, no state change.
  - id_halt: pc_en=0, if_id_flush=1. Next state HALT_DRAIN; counter<=0.
  - id_branch_taken: if_id_flush=1, all enables 1. This takes precedence over imem_miss; the redirect cancels the missing fetch.
  - imem_miss: pc_en=0, if_id_flush=1, downstream enables 1. Next state IMISS.
  - none of the above: all enables 1, no flushes.
- IMISS:
  - Outputs as in the RUN imem_miss case; lu still stalls ID as in RUN.
  - dmem_miss has priority: next state DMISS, imiss_pend<=1.
  - imem_ready: next state RUN; pc_en=1 that cycle.
- DMISS:
  - All enables 0, no flushes.
  - On dmem_ready: next state is IMISS if imiss_pend, else RUN; imiss_pend<=0.
  - dmem_ready with no miss outstanding is ignored.
- HALT_DRAIN:
  - pc_en=0, if_id_flush=1, ex_mem_en=1, mem_wb_en=1.
  - Counter increments each cycle; at DRAIN_CYC-1 the next state is HALTED.
  - dmem_miss pauses the drain: downstream enables 0, counter holds until dmem_ready.
- HALTED: halted=1; pc_en=0 and if_id_en=0 permanently; exited only by reset.
- Reset asserted mid-miss or mid-drain returns the FSM to RUN with no pending flags.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt, lu_cnt and flush_cnt, each CNT_W wide, saturating, reset to 0.
  - stall_cnt increments each cycle pc_en=0 outside HALTED.
  - lu_cnt increments each lu cycle.
  - flush_cnt increments each cycle if_id_flush=1 due to a branch.
- Undefined: the ports and logic are absent; no other behaviour changes.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly 1 cycle with pc_en=0, if_id_en=0, id_ex_flush=1; ex_rd=0 with the same operands -> no stall.
- Branch: id_branch_taken=1 with imem_miss=1 in RUN -> if_id_flush=1, pc_en=1, state stays RUN.
- D-miss: dmem_miss for 4 cycles, then dmem_ready pulse -> all enables 0 for 4 cycles, then RUN with all enables 1.
- Nested miss: imem_miss, then dmem_miss 2 cycles later, dmem_ready, imem_ready 3 cycles later -> DMISS, then IMISS with pc_en=0, then RUN.
- Halt: id_halt=1 -> halted=1 exactly DRAIN_CYC=3 cycles later; with a 2-cycle dmem_miss during drain -> 5 cycles.
- Reset: rst_n low during DMISS -> outputs immediately forced to the reset values; after release, state RUN and pc_en=1.
